panxi_pc_gen: RTL and testbench

PANXI_PC_GEN -- requirements
Module: panxi_pc_gen

---
 rtl/panxi_pc_gen_if.sv | 38 +++
 rtl/panxi_pc_gen.sv | 106 ++++++++++
 tb/tb_panxi_pc_gen.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/panxi_pc_gen_if.sv
// Fetch-side bundle of the PC generator: redirect channels, hold code and fetch handshake.
// The hold-code macros live here so every file compiled after this one sees them.
`ifndef HOLD_WIDTH
`define HOLD_WIDTH 3
`endif
`ifndef HOLD_PC
`define HOLD_PC 3'b001
`endif

interface panxi_pc_gen_if #(
    parameter int DW      = 32,
    parameter int N_REDIR = 3,
    parameter int EPOCH_W = 2
);
    logic [N_REDIR-1:0]    redir_en_xi;
    logic [N_REDIR*DW-1:0] redir_addr_xi;
    logic [`HOLD_WIDTH-1:0] hold_flag_xi;
    logic                  rvc_xi;
    logic                  inst_rdy_xi;
    logic [DW-1:0]         inst_addr_xo;
    logic                  inst_vld_xo;
    logic [EPOCH_W-1:0]    epoch_xo;
    logic                  redir_taken_xo;
    logic                  misalign_xo;
    logic [DW-1:0]         misalign_addr_xo;

    // master = PC generator, slave = redirect sources / fetch unit
    modport master (
        input  redir_en_xi, redir_addr_xi, hold_flag_xi, rvc_xi, inst_rdy_xi,
        output inst_addr_xo, inst_vld_xo, epoch_xo, redir_taken_xo,
               misalign_xo, misalign_addr_xo
    );
    modport slave (
        output redir_en_xi, redir_addr_xi, hold_flag_xi, rvc_xi, inst_rdy_xi,
        input  inst_addr_xo, inst_vld_xo, epoch_xo, redir_taken_xo,
               misalign_xo, misalign_addr_xo
    );
endinterface

// File: rtl/panxi_pc_gen.sv
// Program counter generator: prioritised redirects with alignment check, epoch tagging,
// hold-aware sequential stepping (4 bytes, or 2 for compressed fetches when C_EXT=1).
`ifndef HOLD_WIDTH
`define HOLD_WIDTH 3
`endif
`ifndef HOLD_PC
`define HOLD_PC 3'b001
`endif

module panxi_pc_gen #(
    parameter int            DW        = 32,
    parameter logic [DW-1:0] RESET_VEC = {DW{1'b0}},
    parameter int            N_REDIR   = 3,
    parameter bit            C_EXT     = 1'b0,
    parameter int            EPOCH_W   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           rst_jtag_xi,
    panxi_pc_gen_if.master bus
);
    typedef struct packed {
        logic          vld;
        logic [DW-1:0] addr;
    } redir_sel_t;

    logic [N_REDIR-1:0][DW-1:0] tgt;
    redir_sel_t                 sel;
    logic                       stall, vld, fire, misal;
    logic [DW-1:0]              step;

    logic [DW-1:0]      pc_q, pc_d;
    logic [DW-1:0]      maddr_q, maddr_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic               rdy_q, rdy_d;
    logic               taken_q, taken_d;
    logic               mis_q, mis_d;

    assign tgt   = bus.redir_addr_xi;
    assign stall = bus.hold_flag_xi >= `HOLD_PC;
    assign vld   = rdy_q & ~stall;
    assign fire  = vld & bus.inst_rdy_xi;
    assign step  = (C_EXT && bus.rvc_xi) ? DW'(2) : DW'(4);

    // Walk from the top so the lowest requesting index ends up selected.
    always_comb begin
        sel = '0;
        for (int i = N_REDIR - 1; i >= 0; i--) begin
            if (bus.redir_en_xi[i]) begin
                sel.vld  = 1'b1;
                sel.addr = tgt[i];
            end
        end
    end

    assign misal = sel.addr[0] | (~C_EXT & sel.addr[1]);

    always_comb begin
        pc_d    = pc_q;
        epoch_d = epoch_q;
        maddr_d = maddr_q;
        rdy_d   = 1'b1;
        taken_d = 1'b0;
        mis_d   = 1'b0;
        if (rst_jtag_xi) begin
            pc_d    = RESET_VEC;
            epoch_d = '0;
            rdy_d   = 1'b0;
        end else if (sel.vld && !misal) begin
            pc_d    = sel.addr;
            epoch_d = epoch_q + EPOCH_W'(1);
            taken_d = 1'b1;
        end else if (sel.vld) begin
            // Bad target is dropped; PC keeps streaming state untouched.
            mis_d   = 1'b1;
            maddr_d = sel.addr;
        end else if (fire) begin
            pc_d = pc_q + step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_VEC;
            epoch_q <= '0;
            maddr_q <= '0;
            rdy_q   <= 1'b0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            maddr_q <= maddr_d;
            rdy_q   <= rdy_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
        end
    end

    assign bus.inst_addr_xo     = pc_q;
    assign bus.inst_vld_xo      = vld;
    assign bus.epoch_xo         = epoch_q;
    assign bus.redir_taken_xo   = taken_q;
    assign bus.misalign_xo      = mis_q;
    assign bus.misalign_addr_xo = maddr_q;
endmodule

// File: tb/tb_panxi_pc_gen.sv
// Directed bench for panxi_pc_gen: one instance with C_EXT=0, one with C_EXT=1.
`ifndef HOLD_WIDTH
`define HOLD_WIDTH 3
`endif
`ifndef HOLD_PC
`define HOLD_PC 3'b001
`endif

module tb_panxi_pc_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic jtag0 = 1'b0;
    logic jtag1 = 1'b0;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    panxi_pc_gen_if #(.DW(32), .N_REDIR(3), .EPOCH_W(2)) bus0 ();
    panxi_pc_gen_if #(.DW(32), .N_REDIR(3), .EPOCH_W(2)) bus1 ();

    panxi_pc_gen #(.DW(32), .RESET_VEC(32'h0), .N_REDIR(3), .C_EXT(1'b0), .EPOCH_W(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .rst_jtag_xi(jtag0), .bus(bus0.master)
    );
    panxi_pc_gen #(.DW(32), .RESET_VEC(32'h0), .N_REDIR(3), .C_EXT(1'b1), .EPOCH_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .rst_jtag_xi(jtag1), .bus(bus1.master)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic redir0(input logic [2:0] en, input logic [31:0] a0,
                          input logic [31:0] a1, input logic [31:0] a2);
        bus0.redir_en_xi   = en;
        bus0.redir_addr_xi = {a2, a1, a0};
    endtask

    task automatic redir1(input logic [2:0] en, input logic [31:0] a0);
        bus1.redir_en_xi   = en;
        bus1.redir_addr_xi = {32'h0, 32'h0, a0};
    endtask

    initial begin
        redir0(3'b000, 0, 0, 0);
        redir1(3'b000, 0);
        bus0.hold_flag_xi = '0; bus0.rvc_xi = 1'b0; bus0.inst_rdy_xi = 1'b1;
        bus1.hold_flag_xi = '0; bus1.rvc_xi = 1'b0; bus1.inst_rdy_xi = 1'b0;

        #12;
        chk("rst_addr",  bus0.inst_addr_xo, 32'h0);
        chk("rst_vld",   bus0.inst_vld_xo, 1'b0);
        chk("rst_epoch", bus0.epoch_xo, 2'd0);
        chk("rst_taken", bus0.redir_taken_xo, 1'b0);
        chk("rst_mis",   bus0.misalign_xo, 1'b0);
        chk("rst_maddr", bus0.misalign_addr_xo, 32'h0);
        rst_n = 1'b1;

        // sequential stream after reset release
        tick();
        chk("rel_vld",  bus0.inst_vld_xo, 1'b1);
        chk("seq_0",    bus0.inst_addr_xo, 32'h0);
        tick(); chk("seq_4", bus0.inst_addr_xo, 32'h4);
        tick(); chk("seq_8", bus0.inst_addr_xo, 32'h8);

        // jump to 0x40, then back-pressure from fetch
        redir0(3'b001, 32'h40, 0, 0);
        tick();
        chk("j40_addr",  bus0.inst_addr_xo, 32'h40);
        chk("j40_taken", bus0.redir_taken_xo, 1'b1);
        chk("j40_epoch", bus0.epoch_xo, 2'd1);
        redir0(3'b000, 0, 0, 0);
        bus0.inst_rdy_xi = 1'b0;
        tick(); chk("taken_clr", bus0.redir_taken_xo, 1'b0);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) tick();
            chk("nordy_addr", bus0.inst_addr_xo, 32'h40);
            chk("nordy_vld",  bus0.inst_vld_xo, 1'b1);
        end

        // stall instead of back-pressure
        bus0.inst_rdy_xi = 1'b1;
        bus0.hold_flag_xi = `HOLD_PC;
        #1 chk("stall_vld", bus0.inst_vld_xo, 1'b0);
        tick(); tick();
        chk("stall_addr", bus0.inst_addr_xo, 32'h40);
        chk("stall_vld2", bus0.inst_vld_xo, 1'b0);

        // redirect beats stall; ch1 wins over ch2
        redir0(3'b110, 0, 32'h100, 32'h200);
        tick();
        chk("pri_addr",  bus0.inst_addr_xo, 32'h100);
        chk("pri_taken", bus0.redir_taken_xo, 1'b1);
        chk("pri_epoch", bus0.epoch_xo, 2'd2);
        redir0(3'b000, 0, 0, 0);
        tick();
        chk("pri_once",  bus0.redir_taken_xo, 1'b0);
        chk("pri_hold",  bus0.inst_addr_xo, 32'h100);
        redir0(3'b100, 0, 0, 32'h200);
        tick(); chk("ep3", bus0.epoch_xo, 2'd3);
        redir0(3'b010, 0, 32'h300, 0);
        tick();
        chk("ep_wrap",   bus0.epoch_xo, 2'd0);
        chk("wrap_addr", bus0.inst_addr_xo, 32'h300);
        redir0(3'b000, 0, 0, 0);

        // misaligned ch0 masks aligned ch1
        bus0.hold_flag_xi = '0;
        bus0.inst_rdy_xi = 1'b0;
        redir0(3'b011, 32'h102, 32'h200, 0);
        tick();
        chk("mis_addr",  bus0.inst_addr_xo, 32'h300);
        chk("mis_pulse", bus0.misalign_xo, 1'b1);
        chk("mis_taken", bus0.redir_taken_xo, 1'b0);
        chk("mis_maddr", bus0.misalign_addr_xo, 32'h102);
        chk("mis_epoch", bus0.epoch_xo, 2'd0);
        redir0(3'b000, 0, 0, 0);
        tick();
        chk("mis_clr",   bus0.misalign_xo, 1'b0);
        chk("mis_keep",  bus0.misalign_addr_xo, 32'h102);
        redir0(3'b100, 0, 0, 32'h2);
        tick();
        chk("mis_b1",    bus0.misalign_xo, 1'b1);
        chk("mis_b1a",   bus0.misalign_addr_xo, 32'h2);
        redir0(3'b000, 0, 0, 0);

        // address wrap
        redir0(3'b001, 32'hFFFF_FFFC, 0, 0);
        tick();
        chk("top_addr", bus0.inst_addr_xo, 32'hFFFF_FFFC);
        redir0(3'b000, 0, 0, 0);
        bus0.inst_rdy_xi = 1'b1;
        tick();
        chk("pc_wrap",  bus0.inst_addr_xo, 32'h0);
        chk("wrap_mis", bus0.misalign_xo, 1'b0);

        // jtag reset overrides a same-cycle redirect
        jtag0 = 1'b1;
        redir0(3'b001, 32'h80, 0, 0);
        tick();
        chk("jtag_addr",  bus0.inst_addr_xo, 32'h0);
        chk("jtag_epoch", bus0.epoch_xo, 2'd0);
        chk("jtag_vld",   bus0.inst_vld_xo, 1'b0);
        chk("jtag_taken", bus0.redir_taken_xo, 1'b0);
        jtag0 = 1'b0;
        redir0(3'b000, 0, 0, 0);
        tick();
        chk("jrel_vld",  bus0.inst_vld_xo, 1'b1);
        chk("jrel_addr", bus0.inst_addr_xo, 32'h0);
        tick(); chk("jrel_4", bus0.inst_addr_xo, 32'h4);

        // async reset mid-stream
        rst_n = 1'b0;
        #1;
        chk("arst_addr",  bus0.inst_addr_xo, 32'h0);
        chk("arst_vld",   bus0.inst_vld_xo, 1'b0);
        chk("arst_maddr", bus0.misalign_addr_xo, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("arel_vld",  bus0.inst_vld_xo, 1'b1);
        chk("arel_addr", bus0.inst_addr_xo, 32'h0);

        // compressed stepping on the C_EXT instance
        redir1(3'b001, 32'h10);
        tick();
        chk("c_j10", bus1.inst_addr_xo, 32'h10);
        redir1(3'b000, 0);
        bus1.inst_rdy_xi = 1'b1;
        bus1.rvc_xi = 1'b1;
        tick(); chk("c_12", bus1.inst_addr_xo, 32'h12);
        bus1.rvc_xi = 1'b0;
        tick(); chk("c_16", bus1.inst_addr_xo, 32'h16);
        bus1.inst_rdy_xi = 1'b0;
        redir1(3'b001, 32'h22);
        tick();
        chk("c_j22",   bus1.inst_addr_xo, 32'h22);
        chk("c_j22_m", bus1.misalign_xo, 1'b0);
        chk("c_j22_t", bus1.redir_taken_xo, 1'b1);
        redir1(3'b001, 32'h23);
        tick();
        chk("c_j23_a", bus1.inst_addr_xo, 32'h22);
        chk("c_j23_m", bus1.misalign_xo, 1'b1);
        chk("c_j23_d", bus1.misalign_addr_xo, 32'h23);
        redir1(3'b000, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_err);
        $finish;
    end
endmodule
